// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - parametrised single-clock FIFO with thresholds, sticky errors, flush and FWFT mode
// All flags decode from the registered count; reads/writes are qualified by the pre-edge count only.
module param_sync_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       full,
  output logic                       almost_full,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       empty,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic full_w, empty_w, wr_acc, rd_acc;
  logic [DATA_W-1:0] head_w;

  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);
  assign head_w  = mem_q[rd_ptr_q];

  // Flush wins over both requests, so neither is accepted while clr is high.
  assign wr_acc = wr_en && !full_w && !clr;
  assign rd_acc = rd_en && !empty_w && !clr;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      rd_data_d   = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_en && full_w) overflow_d = 1'b1;
      if (rd_en && empty_w) underflow_d = 1'b1;
      if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        if (FWFT == 0) begin
          rd_data_d  = head_w;
          rd_valid_d = 1'b1;
        end
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left unreset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign rd_data      = (FWFT != 0) ? (empty_w ? '0 : head_w) : rd_data_q;
  assign rd_valid     = (FWFT != 0) ? !empty_w : rd_valid_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb/tb_param_sync_fifo.sv - checks registered-read and FWFT instances against a queue model
module tb_param_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, wr_en, rd_en;
  logic [7:0] wr_data;

  logic       full0, af0, rv0, empty0, ae0, ovf0, unf0;
  logic [7:0] rdata0;
  logic [4:0] count0;
  logic       full1, af1, rv1, empty1, ae1, ovf1, unf1;
  logic [7:0] rdata1;
  logic [4:0] count1;

  int tests = 0;
  int fails = 0;

  logic [7:0] q[$];
  logic       m_ovf, m_unf, m_rv;
  logic [7:0] m_rd;

  always #5 clk = ~clk;

  param_sync_fifo #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .full(full0), .almost_full(af0), .rd_en(rd_en), .rd_data(rdata0), .rd_valid(rv0),
    .empty(empty0), .almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(unf0)
  );

  param_sync_fifo #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .full(full1), .almost_full(af1), .rd_en(rd_en), .rd_data(rdata1), .rd_valid(rv1),
    .empty(empty1), .almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(unf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rv  = 1'b0;
    m_rd  = 8'h00;
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count0", count0, n);
    chk("count1", count1, n);
    chk("full0", full0, n == 16);
    chk("full1", full1, n == 16);
    chk("afull0", af0, n >= 14);
    chk("afull1", af1, n >= 14);
    chk("empty0", empty0, n == 0);
    chk("empty1", empty1, n == 0);
    chk("aempty0", ae0, n <= 2);
    chk("aempty1", ae1, n <= 2);
    chk("ovf0", ovf0, m_ovf);
    chk("ovf1", ovf1, m_ovf);
    chk("unf0", unf0, m_unf);
    chk("unf1", unf1, m_unf);
    chk("rvalid0", rv0, m_rv);
    chk("rdata0", rdata0, m_rd);
    chk("rvalid1", rv1, n != 0);
    chk("rdata1", rdata1, (n != 0) ? q[0] : 8'h00);
  endtask

  // One clock: drive at negedge, model the edge, check at the next negedge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    bit was_full, was_empty;
    wr_en = w; wr_data = d; rd_en = r; clr = c;
    @(posedge clk);
    was_full  = (q.size() == 16);
    was_empty = (q.size() == 0);
    if (c) begin
      model_reset();
    end else begin
      if (w && was_full) m_ovf = 1'b1;
      if (r && was_empty) m_unf = 1'b1;
      m_rv = 1'b0;
      if (r && !was_empty) begin
        m_rd = q.pop_front();
        m_rv = 1'b1;
      end
      if (w && !was_full) q.push_back(d);
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_all();
    cyc(0, 8'h00, 0, 0);

    for (int i = 0; i < 16; i++) cyc(1, 8'h11 + 8'(i), 0, 0);
    cyc(1, 8'hAA, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 1);

    for (int i = 0; i < 10; i++) cyc(1, 8'h20 + 8'(i), 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 8'h00, 1, 0);
    for (int i = 0; i < 10; i++) cyc(1, 8'h30 + 8'(i), 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 8'h40 + 8'(i), 1, 0);
    cyc(0, 8'h00, 0, 1);

    cyc(1, 8'h5A, 0, 0);
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 1, 0);

    for (int i = 0; i < 17; i++) cyc(1, 8'h60 + 8'(i), 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 8'h00, 1, 0);
    cyc(1, 8'hEE, 0, 1);
    cyc(0, 8'h00, 0, 0);

    for (int i = 0; i < 400; i++) begin
      logic w, r, c;
      int bias;
      bias = ((i / 50) % 2 == 0) ? 75 : 25;
      w = ($urandom_range(0, 99) < bias);
      r = ($urandom_range(0, 99) < (100 - bias));
      c = ($urandom_range(0, 59) == 0);
      cyc(w, 8'($urandom), r, c);
    end

    for (int i = 0; i < 5; i++) cyc(1, 8'h90 + 8'(i), 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 8'h00, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
